// File: rtl/dbus_pkg.sv
// +------------------------------------------------------------------+
// | dbus_pkg : shared data-bus field widths and target-select codes  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package dbus_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef logic sel_t;

  localparam sel_t SEL_T0 = 1'b0;
  localparam sel_t SEL_T1 = 1'b1;
endpackage

`default_nettype wire

// File: rtl/dbus_demux2_if.sv
// +------------------------------------------------------------------+
// | dbus_demux2_if : one request/response data-bus link              |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

interface dbus_demux2_if;
  import dbus_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_we;
  logic [BE_W-1:0]   req_be;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_addr, req_we, req_be, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_be, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

`default_nettype wire

// File: rtl/dbus_addr_dec.sv
// +------------------------------------------------------------------+
// | dbus_addr_dec : masked address compare selecting target 1        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module dbus_addr_dec
  import dbus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SEL_BASE = 32'h1000_0000,
  parameter logic [ADDR_W-1:0] SEL_MASK = 32'hF000_0000
) (
  input  wire logic [ADDR_W-1:0] addr,
  output sel_t                   sel
);

  assign sel = ((addr & SEL_MASK) == SEL_BASE) ? SEL_T1 : SEL_T0;

endmodule

`default_nettype wire

// File: rtl/dbus_demux2.sv
// +------------------------------------------------------------------+
// | dbus_demux2 : 1-to-2 data-bus splitter, in-order merged response |
// | Optional error checking: DBUS_DEMUX_ERR_EN.  Rev 1.0             |
// +------------------------------------------------------------------+
`default_nettype none

module dbus_demux2
  import dbus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SEL_BASE = 32'h1000_0000,
  parameter logic [ADDR_W-1:0] SEL_MASK = 32'hF000_0000,
  parameter int                MAX_OUT  = 2
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  dbus_demux2_if.slave   core,
  dbus_demux2_if.master  t0,
  dbus_demux2_if.master  t1,
  output logic           err_out
);

  localparam int               CNT_W   = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

  logic [CNT_W-1:0] cnt;
  sel_t             cur_sel;
  sel_t             sel;
  logic             rsp_ret;
  logic             busy;
  logic             block;
  logic             req_go;
  logic             accept;
  logic             rsp_take;

  dbus_addr_dec #(
    .SEL_BASE (SEL_BASE),
    .SEL_MASK (SEL_MASK)
  ) u_addr_dec (
    .addr (core.req_addr),
    .sel  (sel)
  );

  assign rsp_ret = (cur_sel == SEL_T1) ? t1.rsp_valid : t0.rsp_valid;
  assign busy    = (cnt != '0);

  // A full window may still accept when a response frees a slot this cycle.
  assign block   = (busy && (sel != cur_sel)) || ((cnt == CNT_MAX) && !rsp_ret);
  assign req_go  = core.req_valid & rst_n & !block;

  assign t0.req_valid = req_go & (sel == SEL_T0);
  assign t1.req_valid = req_go & (sel == SEL_T1);

  assign t0.req_addr  = core.req_addr;
  assign t0.req_we    = core.req_we;
  assign t0.req_be    = core.req_be;
  assign t0.req_wdata = core.req_wdata;
  assign t1.req_addr  = core.req_addr;
  assign t1.req_we    = core.req_we;
  assign t1.req_be    = core.req_be;
  assign t1.req_wdata = core.req_wdata;

  assign core.req_ready = ((sel == SEL_T1) ? t1.req_ready : t0.req_ready) & !block;
  assign accept         = core.req_valid & core.req_ready;

  // Responses with nothing outstanding are never forwarded nor counted.
  assign rsp_take       = rsp_ret & busy;
  assign core.rsp_valid = rsp_take;
  assign core.rsp_rdata = (cur_sel == SEL_T1) ? t1.rsp_rdata : t0.rsp_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      cur_sel <= SEL_T0;
    end else begin
      if (accept) begin
        cur_sel <= sel;
      end
      if (accept && !rsp_take) begin
        cnt <= cnt + CNT_W'(1);
      end else if (rsp_take && !accept) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

`ifdef DBUS_DEMUX_ERR_EN
  logic err;
  logic spurious;

  assign spurious = (!busy && (t0.rsp_valid || t1.rsp_valid)) ||
                    ((cur_sel == SEL_T1) ? t0.rsp_valid : t1.rsp_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (spurious) begin
      err <= 1'b1;
    end
  end

  assign err_out = err;
`else
  assign err_out = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dbus_demux2.sv
// +------------------------------------------------------------------+
// | tb_dbus_demux2 : vector table + response scoreboard for demux    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_dbus_demux2;

`ifdef DBUS_DEMUX_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic err;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  dbus_demux2_if core_if ();
  dbus_demux2_if t0_if ();
  dbus_demux2_if t1_if ();

  dbus_demux2 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .core    (core_if),
    .t0      (t0_if),
    .t1      (t1_if),
    .err_out (err)
  );

  typedef struct {
    logic        valid;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rdy0;
    logic        rdy1;
    logic        exp_v0;
    logic        exp_v1;
    logic        exp_rdy;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic req(input logic v, input logic [31:0] a, input logic we,
                     input logic [3:0] be, input logic [31:0] wd);
    core_if.req_valid = v;
    core_if.req_addr  = a;
    core_if.req_we    = we;
    core_if.req_be    = be;
    core_if.req_wdata = wd;
  endtask

  task automatic rsp_off();
    t0_if.rsp_valid = 1'b0;
    t1_if.rsp_valid = 1'b0;
  endtask

  // Drive a response expected to reach the core; its data goes to the scoreboard.
  task automatic rsp_fwd(input logic port, input logic [31:0] d);
    if (port) begin
      t1_if.rsp_valid = 1'b1;
      t1_if.rsp_rdata = d;
    end else begin
      t0_if.rsp_valid = 1'b1;
      t0_if.rsp_rdata = d;
    end
    sb.push_back(d);
  endtask

  always @(negedge clk) begin
    #3;
    if (core_if.rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL rsp_unexpected: got rdata %h expected no response", core_if.rsp_rdata);
      end else begin
        chk("rsp_rdata", core_if.rsp_rdata, sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0100, 1'b0, 4'hF, 32'h1111_1111, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 32'h1000_0004, 1'b1, 4'h3, 32'h2222_2222, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 32'h1FFF_FFFC, 1'b0, 4'h1, 32'h3333_3333, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 32'h2000_0000, 1'b1, 4'hC, 32'h4444_4444, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 32'hF000_0000, 1'b0, 4'h8, 32'h5555_5555, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 32'h1000_0000, 1'b1, 4'hF, 32'h6666_6666, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 32'h0000_0000, 1'b0, 4'h2, 32'h7777_7777, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 32'h1000_0000, 1'b0, 4'h4, 32'h8888_8888, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    // Reset with a live request and a stray response on the inputs.
    rst_n = 1'b0;
    req(1'b1, 32'h0000_0000, 1'b0, 4'hF, 32'h0);
    t0_if.req_ready = 1'b1;
    t1_if.req_ready = 1'b1;
    t0_if.rsp_valid = 1'b1;
    t0_if.rsp_rdata = 32'h0BAD_0000;
    t1_if.rsp_valid = 1'b0;
    t1_if.rsp_rdata = 32'h0;
    @(negedge clk); #2;
    chk("rst_t0_valid", t0_if.req_valid, 1'b0);
    chk("rst_rsp_valid", core_if.rsp_valid, 1'b0);
    chk("rst_err", err, 1'b0);
    @(negedge clk);
    core_if.req_addr = 32'h1000_0000;
    #2;
    chk("rst_t1_valid", t1_if.req_valid, 1'b0);
    @(negedge clk);
    req(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    rsp_off();
    rst_n = 1'b1;

    // Single-transaction steering table.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      t0_if.req_ready = vecs[i].rdy0;
      t1_if.req_ready = vecs[i].rdy1;
      req(vecs[i].valid, vecs[i].addr, vecs[i].we, vecs[i].be, vecs[i].wdata);
      #2;
      chk($sformatf("v%0d_t0_valid", i), t0_if.req_valid, vecs[i].exp_v0);
      chk($sformatf("v%0d_t1_valid", i), t1_if.req_valid, vecs[i].exp_v1);
      chk($sformatf("v%0d_ready", i), core_if.req_ready, vecs[i].exp_rdy);
      chk($sformatf("v%0d_t0_addr", i), t0_if.req_addr, vecs[i].addr);
      chk($sformatf("v%0d_t1_wdata", i), t1_if.req_wdata, vecs[i].wdata);
      chk($sformatf("v%0d_t1_be", i), t1_if.req_be, vecs[i].be);
      chk($sformatf("v%0d_t0_we", i), t0_if.req_we, vecs[i].we);
      @(negedge clk);
      core_if.req_valid = 1'b0;
      if (vecs[i].valid && vecs[i].exp_rdy) begin
        rsp_fwd(vecs[i].exp_v1, 32'hC000_0000 | i);
        #2;
        chk($sformatf("v%0d_rsp_valid", i), core_if.rsp_valid, 1'b1);
      end
      @(negedge clk);
      rsp_off();
    end
    chk("table_err", err, 1'b0);
    t0_if.req_ready = 1'b1;
    t1_if.req_ready = 1'b1;

    // Back-to-back loads to t0 with overlapping responses.
    @(negedge clk);
    req(1'b1, 32'h0000_0100, 1'b0, 4'hF, 32'h0);
    #2;
    chk("b2b_t0_valid0", t0_if.req_valid, 1'b1);
    chk("b2b_ready0", core_if.req_ready, 1'b1);
    @(negedge clk);
    req(1'b1, 32'h0000_0104, 1'b0, 4'hF, 32'h0);
    rsp_fwd(1'b0, 32'hAAAA_0001);
    #2;
    chk("b2b_ready1", core_if.req_ready, 1'b1);
    chk("b2b_rsp_valid1", core_if.rsp_valid, 1'b1);
    @(negedge clk);
    core_if.req_valid = 1'b0;
    rsp_fwd(1'b0, 32'hAAAA_0002);
    #2;
    chk("b2b_rsp_valid2", core_if.rsp_valid, 1'b1);
    @(negedge clk);
    rsp_off();
    t1_if.req_ready = 1'b0;
    req(1'b1, 32'h1000_0000, 1'b0, 4'hF, 32'h0);
    #2;
    chk("b2b_drained_t1_valid", t1_if.req_valid, 1'b1);
    @(negedge clk);
    core_if.req_valid = 1'b0;
    t1_if.req_ready = 1'b1;

    // MAX_OUT window with a slow first response.
    @(negedge clk);
    req(1'b1, 32'h0000_0200, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    req(1'b1, 32'h0000_0204, 1'b0, 4'hF, 32'h0);
    #2;
    chk("max_ready_second", core_if.req_ready, 1'b1);
    @(negedge clk);
    req(1'b1, 32'h0000_0208, 1'b0, 4'hF, 32'h0);
    #2;
    chk("max_ready_full_a", core_if.req_ready, 1'b0);
    chk("max_t0_valid_full", t0_if.req_valid, 1'b0);
    @(negedge clk); #2;
    chk("max_ready_full_b", core_if.req_ready, 1'b0);
    @(negedge clk);
    rsp_fwd(1'b0, 32'hAAAA_0003);
    #2;
    chk("max_ready_on_rsp", core_if.req_ready, 1'b1);
    chk("max_t0_valid_on_rsp", t0_if.req_valid, 1'b1);
    @(negedge clk);
    rsp_off();
    req(1'b1, 32'h0000_020C, 1'b0, 4'hF, 32'h0);
    #2;
    chk("max_still_full", core_if.req_ready, 1'b0);
    @(negedge clk);
    core_if.req_valid = 1'b0;
    rsp_fwd(1'b0, 32'hAAAA_0004);
    @(negedge clk);
    rsp_off();
    rsp_fwd(1'b0, 32'hAAAA_0005);
    @(negedge clk);
    rsp_off();

    // Target switch t0 -> t1 waits for the drain.
    @(negedge clk);
    req(1'b1, 32'h0000_0010, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    req(1'b1, 32'h1000_0004, 1'b1, 4'hF, 32'hDEAD_BEEF);
    #2;
    chk("sw_t1_valid_a", t1_if.req_valid, 1'b0);
    chk("sw_ready_a", core_if.req_ready, 1'b0);
    @(negedge clk); #2;
    chk("sw_t1_valid_b", t1_if.req_valid, 1'b0);
    @(negedge clk);
    rsp_fwd(1'b0, 32'hAAAA_0010);
    #2;
    chk("sw_t1_valid_rsp", t1_if.req_valid, 1'b0);
    @(negedge clk);
    rsp_off();
    #2;
    chk("sw_t1_valid", t1_if.req_valid, 1'b1);
    chk("sw_t0_valid", t0_if.req_valid, 1'b0);
    chk("sw_ready", core_if.req_ready, 1'b1);
    chk("sw_t1_addr", t1_if.req_addr, 32'h1000_0004);
    chk("sw_t1_wdata", t1_if.req_wdata, 32'hDEAD_BEEF);
    chk("sw_t1_be", t1_if.req_be, 4'hF);
    chk("sw_t1_we", t1_if.req_we, 1'b1);
    @(negedge clk);
    core_if.req_valid = 1'b0;
    rsp_fwd(1'b1, 32'hBBBB_0001);
    @(negedge clk);
    rsp_off();

    // Reset while two t0 loads are outstanding.
    @(negedge clk);
    req(1'b1, 32'h0000_0300, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    req(1'b1, 32'h0000_0304, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    core_if.req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    t0_if.rsp_valid = 1'b1;
    t0_if.rsp_rdata = 32'hDEAD_0001;
    #2;
    chk("mid_rst_rsp_valid", core_if.rsp_valid, 1'b0);
    @(negedge clk);
    rsp_off();
    #2;
    chk("mid_rst_err", err, EXP_ERR);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("err_cleared", err, 1'b0);

    // Spurious t1 response while t0 owns one transaction.
    @(negedge clk);
    req(1'b1, 32'h0000_0400, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    core_if.req_valid = 1'b0;
    t1_if.rsp_valid = 1'b1;
    t1_if.rsp_rdata = 32'hBAD0_0BAD;
    #2;
    chk("spur_rsp_valid", core_if.rsp_valid, 1'b0);
    @(negedge clk);
    rsp_off();
    rsp_fwd(1'b0, 32'hAAAA_0020);
    #2;
    chk("spur_t0_rsp_valid", core_if.rsp_valid, 1'b1);
    chk("spur_err", err, EXP_ERR);
    @(negedge clk);
    rsp_off();
    #2;
    chk("spur_err_sticky", err, EXP_ERR);

    @(negedge clk);
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dbus_demux2.md
# dbus_demux2

Data-bus splitter between the core load/store path and two data targets: port 0 (data RAM) and port 1 (peripheral space). One initiator request stream is steered to one of two responder ports by address decode, and responses are merged back. Responses from a target return in order. Up to MAX_OUT transactions may be outstanding, but only to one target at a time, so the merged response stream is also in order.

## Interface
- SEL_BASE, 32'h1000_0000: address match value selecting port 1
- SEL_MASK, 32'hF000_0000: bits compared for decode; sel = ((req_addr & SEL_MASK) == SEL_BASE)
- MAX_OUT, 2: maximum outstanding transactions (≥1)
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid_in / req_ready_out  in/out  1  core request handshake
- req_addr_in  in  32  byte address
- req_we_in  in  1  1 = store
- req_be_in  in  4  byte enables
- req_wdata_in  in  32  store data
- rsp_valid_out  out  1  response to core; the core always accepts it
- rsp_rdata_out  out  32  load data
- t0_/t1_ valid_out, ready_in, addr_out[31:0], we_out, be_out[3:0], wdata_out[31:0]: per-target request
- t0_/t1_ rsp_valid_in[1], rsp_rdata_in[32]: per-target response
- err_out  out  1  sticky protocol error (see Configuration)

## Operation
- State: cnt (outstanding count, width $clog2(MAX_OUT+1)), cur_sel (target owning the outstanding transactions).
- rsp_ret = rsp_valid from the target selected by cur_sel.
- block = (cnt != 0 && sel != cur_sel) || (cnt == MAX_OUT && !rsp_ret).
- tN_valid_out = req_valid_in & !block & (sel == N).
- The non-selected target's valid is 0. Address, we, be and wdata are broadcast to both targets.
- req_ready_out = ready of the selected target & !block.
- Accept = req_valid_in & req_ready_out. On accept, cur_sel <= sel.
- cnt update:
  - +1 on accept only
  - −1 on rsp_ret only
  - unchanged when both occur in the same cycle
- rsp_valid_out = rsp_ret & (cnt != 0). rsp_rdata_out = rdata of the cur_sel target.
- Target switch: requests to the other target stall, with ready low, until cnt reaches 0. The switch request is accepted in the cycle cnt becomes 0, which is the cycle after the last response.
- Reset (any time, including mid-transaction): cnt=0, cur_sel=0, err_out=0. All valid outputs are 0 while rst_n=0. Transactions in flight are abandoned; later responses for them are treated as spurious.

## Timing
- Request path is combinational: zero-cycle latency from core to target.
- Response path is combinational: zero-cycle latency from target to core.
- Target valid never depends on the same target's ready. The only combinational path from a target into its own valid is through its response input, when cnt == MAX_OUT.
- Throughput: one transaction per cycle to the same target, with responses overlapping.
- Target-switch penalty: drain time plus 0 extra cycles.

## Configuration
- DBUS_DEMUX_ERR_EN defined: err_out is set, and stays set until reset, on either of:
  - any tN_rsp_valid_in while cnt == 0
  - a response from the target other than cur_sel
  
  The spurious response is dropped; it is never forwarded to the core.
- Not defined: err_out is tied 0, with no checking logic. A spurious response from the non-cur_sel target is still dropped.

## Structure
- Shared package dbus_pkg: SEL_T0 = 1'b0, SEL_T1 = 1'b1 constants; the dbus request field widths (ADDR_W=32, DATA_W=32, BE_W=4).
- One natural sub-module: dbus_addr_dec (combinational, parameters SEL_BASE/SEL_MASK, addr → sel). The counter, state and steering logic stay in dbus_demux2.

## Test plan
- Reset: hold rst_n=0 with req_valid_in=1 → t0/t1 valid 0, rsp_valid_out 0, err_out 0.
- Back-to-back loads to 0x0000_0100 and 0x0000_0104, t0 ready=1, responses 0xAAAA_0001/0xAAAA_0002 one cycle later each → both accepted on consecutive cycles; core sees the two rdata in order; cnt returns to 0.
- MAX_OUT limit: three requests to t0, t0 response delayed 4 cycles → third request sees req_ready_out=0 until the first response; it is accepted in that same cycle; cnt stays 2.
- Target switch: load 0x0000_0010 (t0) outstanding, then store 0x1000_0004 wdata 0xDEAD_BEEF be 4'hF → t1_valid_out stays 0 until the cycle after the t0 response; then t1 gets the store with unchanged fields.
- Reset mid-operation: two t0 loads outstanding, pulse rst_n low, then t0 returns a response → with DBUS_DEMUX_ERR_EN: rsp_valid_out=0 and err_out=1. Without it: rsp_valid_out=0 and err_out=0.
- Spurious t1 response while t0 owns cnt=1 (DBUS_DEMUX_ERR_EN defined) → err_out=1, core response not issued for it; the t0 response still forwarded normally.
